// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle for the load/store unit.
// master = pipeline, slave = load_store_unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 13
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator on one synchronous memory port.
// Define LSU_FAULT_EN for alignment / illegal-size fault reporting.
module load_store_unit #(
  parameter  int MEM_SIZE = 8192,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        mem_be,
  output logic              mem_we
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        wr_q;
  logic        rvalid;
  logic [31:0] rdata;

  logic [1:0]  size_e;
  logic [1:0]  off;
  logic        bad;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ld;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = rvalid;
  assign bus.resp_rdata = rdata;

`ifdef LSU_FAULT_EN
  logic fault_q;
  assign bus.resp_fault = fault_q;
`else
  assign bus.resp_fault = 1'b0;
`endif

  always_comb begin
    size_e = bus.req_size;
    off    = bus.req_addr[1:0];
    bad    = 1'b0;
`ifdef LSU_FAULT_EN
    unique case (1'b1)
      bus.req_size == 2'b11: bad = 1'b1;
      bus.req_size == 2'b10: bad = (off != 2'b00);
      bus.req_size == 2'b01: bad = off[0];
      default:               bad = 1'b0;
    endcase
`else
    // Misaligned offsets truncate like the memory's own address decode.
    if (bus.req_size[1]) begin
      size_e = 2'b10;
      off    = 2'b00;
    end else if (bus.req_size[0]) begin
      off[0] = 1'b0;
    end
`endif
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = bus.req_wdata;
    unique case (size_e)
      2'b00: begin
        be_n = 4'b0001 << off;
        wd_n = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_n = off[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    ld = sh;
    unique case (size_q)
      2'b00: ld = {{24{~uns_q & sh[7]}}, sh[7:0]};
      2'b01: ld = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      mem_we    <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
`ifdef LSU_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q <= size_e;
            off_q  <= off;
            uns_q  <= bus.req_unsigned;
            wr_q   <= bus.req_write;
`ifdef LSU_FAULT_EN
            fault_q <= bad;
`endif
            if (bad) begin
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RESP;
            end else begin
              mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
              mem_we    <= bus.req_write;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          mem_be <= 4'b0000;
          if (wr_q) begin
            rdata  <= '0;
            rvalid <= 1'b1;
            state  <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rdata  <= ld;
          rvalid <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model,
// directed test-plan cases then randomized traffic with random backpressure.
module tb_load_store_unit;
  localparam int AW = 13;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          c0;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_we;

  load_store_unit_if #(.ADDR_W(AW)) bus ();

  load_store_unit #(.MEM_SIZE(8192)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_be    (mem_be),
    .mem_we    (mem_we)
  );

  int          total;
  int          bad;
  int          cyc;
  int          rr_mode;
  exp_t        q[$];
  logic [7:0]  ref_mem [0:8191];
  logic [31:0] mem [0:2047];

  bit          prev_valid;
  bit          prev_we;
  bit          hold;
  bit          after_hs;
  bit          any_mem;
  logic [31:0] held_rdata;
  logic        held_fault;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;

  function automatic logic [31:0] init_word(int w);
    return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Attached synchronous memory: one-cycle read latency, byte-lane writes.
  initial begin
    for (int w = 0; w < 2048; w++) mem[w] = init_word(w);
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++)
        if (mem_we && mem_be[i])
          mem[mem_addr[AW-1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem[mem_addr[AW-1:2]];
    end
  end

  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.resp_ready = 1'b1;
        1:       bus.resp_ready = 1'($urandom_range(0, 1));
        default: bus.resp_ready = 1'b0;
      endcase
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        prev_we    = 0;
        hold       = 0;
        after_hs   = 0;
        continue;
      end
      if (after_hs) chk("ready_after_hs", 32'(bus.req_ready), 1);
      after_hs = 0;
      if (hold) begin
        chk("hold_valid", 32'(bus.resp_valid), 1);
        chk("hold_rdata", bus.resp_rdata, held_rdata);
        chk("hold_fault", 32'(bus.resp_fault), 32'(held_fault));
      end
      if (bus.resp_valid) chk("busy_ready", 32'(bus.req_ready), 0);
      if (bus.resp_valid && !prev_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp act=valid exp=none");
        end else begin
          chk("latency", 32'(cyc - q[0].c0), 32'(q[0].lat));
        end
      end
      if (bus.resp_valid && bus.resp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", bus.resp_rdata, e.rdata);
        chk("fault", 32'(bus.resp_fault), 32'(e.fault));
        after_hs = 1;
      end
      hold       = bus.resp_valid && !bus.resp_ready;
      held_rdata = bus.resp_rdata;
      held_fault = bus.resp_fault;
      prev_valid = bus.resp_valid;
      if (mem_we) begin
        chk("we_pulse", 32'(prev_we), 0);
        cap_be = mem_be;
        cap_wd = mem_wdata;
      end
      if (mem_we || mem_be != 4'b0000) begin
        any_mem = 1;
        chk("addr_align", 32'(mem_addr[1:0]), 0);
      end
      prev_we = mem_we;
    end
  end

  task automatic req_raw(input logic w, input logic [1:0] sz,
                         input logic u, input logic [AW-1:0] a,
                         input logic [31:0] d,
                         output int c0, output bit ok);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    n  = 0;
    ok = 1;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL accept_timeout act=%0d exp=<60", n);
        ok = 0;
        break;
      end
    end
    c0 = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic u, input logic [AW-1:0] a,
                        input logic [31:0] d);
    int c0;
    bit ok;
    int n;
    int ea;
    logic [31:0] v;
    exp_t e;
    req_raw(w, sz, u, a, d, c0, ok);
    if (!ok) return;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ea = int'(a);
`ifdef LSU_FAULT_EN
    e.fault = (sz == 2'b11) || (n > 1 && (ea % n) != 0);
`else
    e.fault = 1'b0;
    ea = ea - (ea % n);
`endif
    e.c0 = c0;
    if (e.fault) begin
      e.rdata = '0;
      e.lat   = 1;
    end else if (w) begin
      for (int i = 0; i < n; i++) ref_mem[ea+i] = d[8*i +: 8];
      e.rdata = '0;
      e.lat   = 2;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++)
        v = v | (32'(ref_mem[ea+i]) << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      e.rdata = v;
      e.lat   = 3;
    end
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int c0;
    bit ok;
    total   = 0;
    bad     = 0;
    rr_mode = 0;
    any_mem = 0;
    for (int w = 0; w < 2048; w++)
      for (int i = 0; i < 4; i++)
        ref_mem[4*w+i] = init_word(w) >> (8 * i);
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    do_req(1, 2'b10, 0, 13'h10, 32'hDEADBEEF);
    drain();
    chk("sw_be", 32'(cap_be), 32'hF);
    do_req(0, 2'b10, 0, 13'h10, 0);
    do_req(1, 2'b00, 0, 13'h21, 32'h00000080);
    drain();
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wd, 32'h80808080);
    do_req(0, 2'b00, 0, 13'h21, 0);
    do_req(0, 2'b00, 1, 13'h21, 0);
    do_req(1, 2'b01, 0, 13'h32, 32'h00001234);
    drain();
    chk("sh_be", 32'(cap_be), 32'hC);
    do_req(0, 2'b01, 0, 13'h32, 0);
    do_req(0, 2'b10, 0, 13'h30, 0);
    drain();
    any_mem = 0;
    do_req(0, 2'b10, 0, 13'h13, 0);
    drain();
`ifdef LSU_FAULT_EN
    chk("fault_no_mem", 32'(any_mem), 0);
`else
    chk("nofault_mem", 32'(any_mem), 1);
`endif

    // Backpressure: response held 5+ cycles, extra request must be ignored.
    rr_mode = 2;
    repeat (2) @(posedge clk);
    do_req(0, 2'b10, 0, 13'h10, 0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b10;
      bus.req_addr  = 13'h50;
      bus.req_wdata = 32'h55AA55AA;
      @(negedge clk);
      chk("bp_valid", 32'(bus.resp_valid), 1);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rr_mode = 0;
    drain();
    do_req(0, 2'b10, 0, 13'h50, 0);
    drain();

    // Reset during the ISSUE cycle of a store must drop the write.
    do_req(1, 2'b10, 0, 13'h40, 32'h11223344);
    drain();
    req_raw(1, 2'b10, 0, 13'h40, 32'hCAFEF00D, c0, ok);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ir_mem_we", 32'(mem_we), 0);
    chk("ir_mem_be", 32'(mem_be), 0);
    chk("ir_mem_addr", 32'(mem_addr), 0);
    chk("ir_mem_wdata", mem_wdata, 0);
    chk("ir_resp_valid", 32'(bus.resp_valid), 0);
    chk("ir_resp_rdata", bus.resp_rdata, 0);
    chk("ir_req_ready", 32'(bus.req_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 2'b10, 0, 13'h40, 0);
    drain();

    rr_mode = 1;
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 8191));
      else a = AW'($urandom_range(0, 127));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();
    rr_mode = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
